// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// registers the fetched word into IF/ID, with stall, flush and halt handling.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_instr_o,
  output logic        ifid_valid_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] cycle_cnt_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [31:0] LAST_PC = 32'(4 * (IMEM_WORDS - 1));

  logic [1:0]  state;
  logic [31:0] pc_p0;
  logic [31:0] ifid_pc_p1;
  logic [31:0] ifid_instr_p1;
  logic        vld_p1;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] cycle_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [31:0] align_target(input logic [31:0] t);
    return {t[31:2], 2'b00};
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      pc_p0         <= RESET_PC;
      ifid_pc_p1    <= RESET_PC;
      ifid_instr_p1 <= NOP_INSTR;
      vld_p1        <= 1'b0;
      stall_cnt     <= '0;
      flush_cnt     <= '0;
      cycle_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) state <= S_RUN;
        end
        S_RUN, S_HALT: begin
          if (start_i) begin
            cycle_cnt <= sat_inc(cycle_cnt);
            // Stall wins over flush; decode re-presents the branch once the bubble clears.
            if (stall_i) begin
              stall_cnt <= sat_inc(stall_cnt);
            end else if (flush_i) begin
              pc_p0         <= align_target(branch_target_i);
              ifid_pc_p1    <= pc_p0;
              ifid_instr_p1 <= NOP_INSTR;
              vld_p1        <= 1'b0;
              flush_cnt     <= sat_inc(flush_cnt);
              state         <= S_RUN;
            end else if (state == S_RUN) begin
              // IF -> IF/ID boundary
              ifid_pc_p1    <= pc_p0;
              ifid_instr_p1 <= imem_instr_i;
              vld_p1        <= 1'b1;
              if (pc_p0 >= LAST_PC) state <= S_HALT;
              else                  pc_p0 <= pc_p0 + 32'd4;
            end else begin
              ifid_pc_p1    <= pc_p0;
              ifid_instr_p1 <= NOP_INSTR;
              vld_p1        <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign imem_addr_o  = pc_p0;
  assign pc_o         = pc_p0;
  assign ifid_pc_o    = ifid_pc_p1;
  assign ifid_instr_o = ifid_instr_p1;
  assign ifid_valid_o = vld_p1;
  assign stall_cnt_o  = stall_cnt;
  assign flush_cnt_o  = flush_cnt;
  assign cycle_cnt_o  = cycle_cnt;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipelined CPU: owns the program counter, drives the combinational instruction-memory address, and registers the fetched word into the IF/ID pipeline register. It applies hazard-unit stalls and branch-resolution flushes, and exposes stall, flush and cycle counters that the bench and the decode stage read directly.

## Interface
- RESET_PC, 32'h0000_0000: PC value after reset.
- IMEM_WORDS, 256: instruction-memory depth in 32-bit words; the last valid fetch address is 4*(IMEM_WORDS-1).
- NOP_INSTR, 32'h0000_0000: word inserted into IF/ID on flush, halt or idle.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  run enable; low freezes the stage.
- stall_i  in  1  hazard-unit bubble request; holds PC and IF/ID.
- flush_i  in  1  taken branch resolved in ID; discard IF/ID and redirect.
- branch_target_i  in  32  redirect PC, valid with flush_i.
- imem_addr_o  out  32  instruction-memory byte address (= pc_o).
- imem_instr_i  in  32  combinational instruction word for imem_addr_o.
- pc_o  out  32  current PC.
- ifid_pc_o  out  32  PC of the instruction in IF/ID.
- ifid_instr_o  out  32  instruction in IF/ID.
- ifid_valid_o  out  1  IF/ID holds a real fetched instruction.
- stall_cnt_o  out  32  accepted stall cycles.
- flush_cnt_o  out  32  accepted flushes.
- cycle_cnt_o  out  32  cycles spent in RUN.

## Operation
- States: IDLE, RUN, HALT. Reset -> IDLE.
- IDLE: PC held at RESET_PC; IF/ID = {RESET_PC, NOP_INSTR, valid=0}. start_i sampled high at a posedge -> RUN. No fetch occurs on that edge.
- RUN, start_i low: everything holds, counters included. The state stays RUN.
- RUN, start_i high, per posedge, with priority stall > flush > normal:
  - stall_i=1: PC and IF/ID hold; stall_cnt += 1. Any concurrent flush_i is ignored and not counted, because decode re-presents it.
  - flush_i=1: PC <- branch_target_i; IF/ID <- {pc_o, NOP_INSTR, valid=0}; flush_cnt += 1.
  - normal: IF/ID <- {pc_o, imem_instr_i, valid=1}. If pc_o == 4*(IMEM_WORDS-1), PC holds and the state goes to HALT; otherwise PC <- pc_o + 4.
  - cycle_cnt += 1 on every RUN cycle with start_i high, whether stalled or not.
- HALT: PC frozen. IF/ID <- {pc_o, NOP_INSTR, valid=0} each cycle. cycle_cnt keeps counting while start_i is high. Stall behaviour is unchanged. An accepted flush_i redirects PC, is counted, and returns the stage to RUN.
- branch_target_i bits [1:0] are forced to 0 when loaded. Targets at or beyond 4*IMEM_WORDS load normally; the next normal fetch then enters HALT.
- PC arithmetic is 32-bit modulo. Counters saturate at 32'hFFFF_FFFF.

## Timing
- Reset (asynchronous, immediate): pc_o=RESET_PC, imem_addr_o=RESET_PC, ifid_pc_o=RESET_PC, ifid_instr_o=NOP_INSTR, ifid_valid_o=0, all counters 0, state IDLE.
- Reset asserted mid-operation discards all in-flight state within the same cycle. After reset release, the stage needs a fresh start_i posedge.
- imem_addr_o is combinational from the PC register, with zero latency.
- Fetch latency is 1 cycle: the word at pc_o at edge N appears on ifid_instr_o after edge N.
- Flush latency is 1 cycle: branch_target_i is on pc_o after the flush edge, and the target instruction is in IF/ID one edge later.
- stall_i and flush_i are sampled only at posedges. They have no effect in IDLE.
- All outputs are registered except imem_addr_o.

## Test plan
- Reset/idle: hold start_i=0 for 3 cycles -> pc_o=0, ifid_valid_o=0, all counters 0. Assert rst_i mid-RUN at PC=0x10 -> pc_o=0 immediately, state IDLE.
- Sequential fetch: load memory words 0..3 = 0xA,0xB,0xC,0xD, raise start_i, run 4 cycles -> ifid_instr_o = 0xA,0xB,0xC,0xD with ifid_pc_o = 0,4,8,12; cycle_cnt_o=4.
- Stall: at pc_o=8 assert stall_i for 2 cycles -> pc_o stays 8, IF/ID holds {4,0xB}, stall_cnt_o=2. Fetch then resumes with 0xC.
- Flush: at pc_o=0xC assert flush_i with target 0x40 (word 16 = 0x1234) -> next edge gives pc_o=0x40, ifid_valid_o=0, ifid_instr_o=0, flush_cnt_o=1. The following edge gives ifid_instr_o=0x1234.
- Stall+flush together: both asserted for 1 cycle -> stall_cnt +1, flush_cnt unchanged, PC holds. Then flush alone -> redirect, flush_cnt +1.
- Halt: IMEM_WORDS=4, run from 0 -> after pc_o=12 is fetched, state HALT with pc_o=12 and ifid_valid_o=0 thereafter. A flush to target 0 returns the stage to RUN, with word 0 fetched 2 cycles later.
